// File: rtl/uart_word_assembler.sv
// uart_word_assembler: rebuilds 16-bit words (high byte first) from the
// uart_receiver byte strobes and presents them on a valid/ready register
// with sticky error flags.
// Optional: define UART_WORD_CHECKSUM_EN to require a third byte equal to
// hi^lo per word (adds WAIT_CK state and the cks_flag output).
module uart_word_assembler #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int TO_W           = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Rx_DATA,
    input  logic        Rx_VALID,
    input  logic        Rx_FERROR,
    input  logic        Rx_PERROR,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    input  logic        err_clr,
    output logic        ferr_flag,
    output logic        perr_flag,
    output logic        to_flag,
`ifdef UART_WORD_CHECKSUM_EN
    output logic        cks_flag,
`endif
    output logic        ovf_flag
);

    localparam logic [1:0] WAIT_HI = 2'd0;
    localparam logic [1:0] WAIT_LO = 2'd1;
`ifdef UART_WORD_CHECKSUM_EN
    localparam logic [1:0] WAIT_CK = 2'd2;
`endif
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
    localparam bit              TO_EN  = (TIMEOUT_CYCLES != 0);

    logic [1:0]      state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            vld_prev_q, err_prev_q;
    logic [15:0]     word_q, word_d;
    logic            wvld_q, wvld_d;
    logic            ferr_q, perr_q, to_q, ovf_q;
    logic            ferr_d, perr_d, to_d, ovf_d;
`ifdef UART_WORD_CHECKSUM_EN
    logic [7:0]      lo_q, lo_d;
    logic            cks_q, cks_d;
`endif

    logic        byte_ev, err_ev, to_hit;
    logic        cmpl, load, to_set, cks_set;
    logic [15:0] cmpl_word;

    // One event per receiver byte / error, however long the level stays high.
    assign byte_ev = Rx_VALID & ~vld_prev_q;
    assign err_ev  = (Rx_FERROR | Rx_PERROR) & ~err_prev_q;
    assign to_hit  = TO_EN && (cnt_q >= TO_LIM);

    // Byte sequencing: error beats timeout, timeout beats a completing byte.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        cmpl      = 1'b0;
        cmpl_word = {hi_q, Rx_DATA};
        to_set    = 1'b0;
        cks_set   = 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
        lo_d      = lo_q;
`endif
        if (err_ev) begin
            state_d = WAIT_HI;
            cnt_d   = '0;
        end else if (state_q == WAIT_HI) begin
            if (byte_ev) begin
                hi_d    = Rx_DATA;
                cnt_d   = '0;
                state_d = WAIT_LO;
            end
        end else if (to_hit) begin
            // Stale high byte is dropped; a byte arriving now starts a new word.
            to_set = 1'b1;
            cnt_d  = '0;
            if (byte_ev) begin
                hi_d    = Rx_DATA;
                state_d = WAIT_LO;
            end else begin
                state_d = WAIT_HI;
            end
        end else if (byte_ev) begin
`ifdef UART_WORD_CHECKSUM_EN
            if (state_q == WAIT_LO) begin
                lo_d    = Rx_DATA;
                cnt_d   = '0;
                state_d = WAIT_CK;
            end else begin
                state_d = WAIT_HI;
                if (Rx_DATA == (hi_q ^ lo_q)) begin
                    cmpl      = 1'b1;
                    cmpl_word = {hi_q, lo_q};
                end else begin
                    cks_set = 1'b1;
                end
            end
`else
            cmpl    = 1'b1;
            state_d = WAIT_HI;
`endif
        end else if (cnt_q != {TO_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output register and sticky flags; a set in the same cycle beats err_clr.
    always_comb begin
        load   = cmpl & (~wvld_q | word_ready);
        wvld_d = load | (wvld_q & ~word_ready);
        word_d = load ? cmpl_word : word_q;
        ferr_d = (ferr_q & ~err_clr) | (err_ev & Rx_FERROR);
        perr_d = (perr_q & ~err_clr) | (err_ev & Rx_PERROR);
        to_d   = (to_q & ~err_clr) | to_set;
        ovf_d  = (ovf_q & ~err_clr) | (cmpl & ~load);
`ifdef UART_WORD_CHECKSUM_EN
        cks_d  = (cks_q & ~err_clr) | cks_set;
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WAIT_HI;
            hi_q       <= '0;
            cnt_q      <= '0;
            vld_prev_q <= 1'b0;
            err_prev_q <= 1'b0;
            word_q     <= '0;
            wvld_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            to_q       <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
            lo_q       <= '0;
            cks_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            vld_prev_q <= Rx_VALID;
            err_prev_q <= Rx_FERROR | Rx_PERROR;
            word_q     <= word_d;
            wvld_q     <= wvld_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            to_q       <= to_d;
            ovf_q      <= ovf_d;
`ifdef UART_WORD_CHECKSUM_EN
            lo_q       <= lo_d;
            cks_q      <= cks_d;
`endif
        end
    end

    assign word_out   = word_q;
    assign word_valid = wvld_q;
    assign ferr_flag  = ferr_q;
    assign perr_flag  = perr_q;
    assign to_flag    = to_q;
    assign ovf_flag   = ovf_q;
`ifdef UART_WORD_CHECKSUM_EN
    assign cks_flag   = cks_q;
`endif

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Receive-side stage directly downstream of uart_receiver.
- Consumes the receiver's byte strobes and status flags, and rebuilds 16-bit words from byte pairs sent high byte first.
- Presents each word on a valid/ready output register to the consumer, with sticky error reporting.
- Provides the data_out path of the channel with a proper handshake instead of direct byte muxing.

Parameters:
- TIMEOUT_CYCLES, 200000: max clk cycles allowed between high-byte capture and low-byte capture; 0 disables the timeout.
- TO_W, 18: width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- Rx_DATA  input  8  received byte from uart_receiver.
- Rx_VALID  input  1  receiver byte-valid; may stay high for several cycles.
- Rx_FERROR  input  1  receiver framing error.
- Rx_PERROR  input  1  receiver parity error.
- word_out  output  16  assembled word, {high byte, low byte}.
- word_valid  output  1  word_out holds an unread word.
- word_ready  input  1  consumer accepts word_out.
- err_clr  input  1  single-cycle clear of all sticky error flags.
- ferr_flag  output  1  sticky: framing error seen.
- perr_flag  output  1  sticky: parity error seen.
- to_flag  output  1  sticky: inter-byte timeout.
- ovf_flag  output  1  sticky: completed word dropped because output was full.

Behaviour:
- Reset (reset=0, async): state=WAIT_HI; word_out=16'h0000; word_valid=0; all flags=0; timeout counter=0; edge-detect registers=0.
- Byte event: rising edge of Rx_VALID, from a registered previous value. Exactly one event per receiver byte, regardless of how long Rx_VALID stays high.
- Error event: rising edge of (Rx_FERROR | Rx_PERROR).
  - Sets ferr_flag and/or perr_flag according to which input rose.
  - Discards any partial word and forces state to WAIT_HI.
  - If a byte event occurs in the same cycle, the error wins and the byte is discarded.
- WAIT_HI: on byte event, hi_reg <= Rx_DATA, clear timeout counter, go to WAIT_LO.
- WAIT_LO:
  - Counter increments each cycle; counter value saturates.
  - On byte event: word is complete; go to WAIT_HI.
  - If counter reaches TIMEOUT_CYCLES before a byte event: set to_flag, drop hi_reg, go to WAIT_HI. A byte event in that same cycle is treated as a new high byte.
- Word complete:
  - If word_valid=0, or word_valid=1 with word_ready=1 in the same cycle: word_out <= {hi_reg, Rx_DATA} and word_valid=1 on the next cycle.
  - Latency is 1 clk from the low-byte event to word_valid.
  - Otherwise: the word is dropped, ovf_flag is set, and word_out is unchanged.
- Handshake:
  - Transfer occurs when word_valid & word_ready.
  - word_valid clears on the next cycle unless a new word loads in the same cycle; back-to-back loads are allowed.
  - word_out is stable while word_valid=1 and word_ready=0.
- err_clr: clears all sticky flags on the next edge. A flag-setting event in the same cycle takes priority, so the flag stays 1.
- Flags never affect word_valid or word_out.

Optional Feature:
- Macro: UART_WORD_CHECKSUM_EN.
- Defined:
  - Adds state WAIT_CK after WAIT_LO. The third byte must equal hi^lo.
  - On match, the word loads the output per the word-complete rules.
  - On mismatch, the word is dropped and output cks_flag (1 bit, sticky, cleared by err_clr) is set.
  - The timeout applies in WAIT_CK as in WAIT_LO; the counter is cleared on the low-byte event.
  - Latency is 1 clk from the checksum byte event.
- Undefined: cks_flag port and WAIT_CK are absent; words are two bytes.

Test Plan:
- Basic word: byte events 8'hA5 then 8'h3C, word_ready=1 → word_out=16'hA53C, word_valid high exactly 1 cycle, 1 clk after the second event; no flags.
- Held valid: Rx_VALID held high 20 cycles per byte, bytes 8'h12, 8'h34 → exactly one word 16'h1234.
- Backpressure/overflow: word_ready=0; send 16'h1111 then 16'h2222 → word_out stays 16'h1111, ovf_flag=1. Raise word_ready 1 cycle → word_valid=0. Pulse err_clr → ovf_flag=0.
- Timeout: TIMEOUT_CYCLES=50; send 8'hFF then nothing for 60 cycles → to_flag=1, no word. Then send 8'h01, 8'h02 → word_out=16'h0102.
- Error mid-word: high byte 8'hAA, then Rx_PERROR rises together with byte 8'hBB → perr_flag=1, no word. The next two bytes 8'hC0, 8'hDE → 16'hC0DE.
- Reset mid-word / checksum: assert reset in WAIT_LO → all outputs are 0 immediately (async). With UART_WORD_CHECKSUM_EN: bytes 8'h0F, 8'hF0, 8'hFF → 16'h0FF0; bytes 8'h0F, 8'hF0, 8'h00 → cks_flag=1, no word.
